// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display driver.
// The segment table is held in active-low form (bit 6 = a ... bit 0 = g).
package seg7_pkg;

    localparam int DIGITS = 4;
    localparam int DIG_W  = $clog2(DIGITS);
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Packed so that HEX_SEG[n] is the pattern for hex digit n.
    localparam logic [15:0][6:0] HEX_SEG = '{
        7'b0111000,  // F
        7'b0110000,  // E
        7'b1000010,  // d
        7'b0110001,  // C
        7'b1100000,  // b
        7'b0001000,  // A
        7'b0000100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return HEX_SEG[nib];
    endfunction

    // A digit is blanked when it and every digit to its left are zero; digit 0 always shows.
    function automatic logic lz_blank(input logic [15:0] val,
                                      input logic [DIG_W-1:0] idx,
                                      input logic en);
        logic blank;
        blank = 1'b0;
        if (en) begin
            case (idx)
                2'd3:    blank = (val[15:12] == 4'h0);
                2'd2:    blank = (val[15:8] == 8'h00);
                2'd1:    blank = (val[15:4] == 12'h000);
                default: blank = 1'b0;
            endcase
        end
        return blank;
    endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// Display-side bundle: scan tick, value load handshake, blanking control and
// the multiplexed segment/anode outputs.
interface seg7_scan_if;

    logic        scan_tick_in;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        blank_lz;
    logic        load_ack;
    logic        frame_start;
    logic [3:0]  an;
    logic [6:0]  a_to_g;
    logic        dp;

    modport master (
        output scan_tick_in, data_in, dp_in, load, blank_lz,
        input  load_ack, frame_start, an, a_to_g, dp
    );

    modport slave (
        input  scan_tick_in, data_in, dp_in, load, blank_lz,
        output load_ack, frame_start, an, a_to_g, dp
    );

endinterface

// File: rtl/seg7_scan_hex7seg.sv
// Combinational hex nibble to 7-segment decoder, active-low pattern out.
module hex7seg
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nib);

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed 4-digit 7-segment driver: steps one digit per rising edge of
// the slow scan tick and swaps in newly loaded values only at frame boundaries.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter bit SYNC_EN        = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        clr_n,
    seg7_scan_if.slave  bus
);

    localparam logic [3:0] AN_IDLE  = AN_ACTIVE_LOW  ? 4'hF : 4'h0;
    localparam logic [6:0] SEG_IDLE = SEG_ACTIVE_LOW ? SEG_OFF : ~SEG_OFF;
    localparam logic       DP_IDLE  = SEG_ACTIVE_LOW;
    localparam logic [DIG_W-1:0] LAST_DIG = DIG_W'(DIGITS - 1);

    logic             src;
    logic             prev;
    logic             step;
    logic             commit;
    logic             do_ack;
    logic [DIG_W-1:0] dig;
    logic [15:0]      disp_val;
    logic [3:0]       disp_dp;
    logic [15:0]      pend_val;
    logic [3:0]       pend_dp;
    logic             pend_flag;
    logic             ack_q;
    logic             fs_q;
    logic [3:0]       nib;
    logic [6:0]       seg_raw;
    logic             blank;
    logic [3:0]       an_oh;
    logic             dp_on;
    logic [3:0]       an_q;
    logic [6:0]       seg_q;
    logic             dp_q;

    generate
        if (SYNC_EN) begin : g_sync
            logic sync0;
            logic sync1;
            always_ff @(posedge clk) begin
                if (!clr_n) begin
                    sync0 <= 1'b0;
                    sync1 <= 1'b0;
                end else begin
                    sync0 <= bus.scan_tick_in;
                    sync1 <= sync0;
                end
            end
            assign src = sync1;
        end else begin : g_direct
            assign src = bus.scan_tick_in;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!clr_n) prev <= 1'b0;
        else        prev <= src;
    end

    assign step   = src & ~prev;
    assign commit = step && (dig == LAST_DIG);
    assign do_ack = commit && pend_flag;

    // Digit counter, pending buffer and frame-boundary commit
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            dig       <= '0;
            disp_val  <= '0;
            disp_dp   <= '0;
            pend_val  <= '0;
            pend_dp   <= '0;
            pend_flag <= 1'b0;
            ack_q     <= 1'b0;
            fs_q      <= 1'b0;
        end else begin
            if (step) dig <= dig + 1'b1;
            if (do_ack) begin
                disp_val <= pend_val;
                disp_dp  <= pend_dp;
            end
            // A load landing on the commit edge stays pending for the next frame.
            if (bus.load) begin
                pend_val  <= bus.data_in;
                pend_dp   <= bus.dp_in;
                pend_flag <= 1'b1;
            end else if (do_ack) begin
                pend_flag <= 1'b0;
            end
            ack_q <= do_ack;
            fs_q  <= commit;
        end
    end

    always_comb begin
        nib = 4'h0;
        case (dig)
            2'd0:    nib = disp_val[3:0];
            2'd1:    nib = disp_val[7:4];
            2'd2:    nib = disp_val[11:8];
            default: nib = disp_val[15:12];
        endcase
    end

    hex7seg u_hex7seg (
        .nib (nib),
        .seg (seg_raw)
    );

    always_comb begin
        blank = lz_blank(disp_val, dig, bus.blank_lz);
        an_oh = 4'h0;
        if (!blank) an_oh[dig] = 1'b1;
        dp_on = disp_dp[dig] & ~blank;
    end

    // Output register stage: lags dig by one clock
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            an_q  <= AN_IDLE;
            seg_q <= SEG_IDLE;
            dp_q  <= DP_IDLE;
        end else begin
            an_q  <= AN_ACTIVE_LOW  ? ~an_oh   : an_oh;
            seg_q <= SEG_ACTIVE_LOW ? seg_raw  : ~seg_raw;
            dp_q  <= SEG_ACTIVE_LOW ? ~dp_on   : dp_on;
        end
    end

    assign bus.an          = an_q;
    assign bus.a_to_g      = seg_q;
    assign bus.dp          = dp_q;
    assign bus.load_ack    = ack_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: a frame-level display model checked every cycle, plus
// directed scenarios with hand-computed segment/anode values.
module tb_seg7_scan;

    logic clk = 1'b0;
    logic clr_n;

    seg7_scan_if bus ();

    seg7_scan #(
        .SYNC_EN        (1'b1),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Active-low patterns for hex digits 0..F
    localparam logic [6:0] SEG_TAB [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    int total = 0;
    int bad   = 0;
    int ack_seen = 0;
    int fs_seen  = 0;

    // Model state
    bit          mvalid = 1'b0;
    logic [2:0]  hist;
    int          cnt;
    logic [15:0] mdisp, mpend;
    logic [3:0]  mddp, mpdp;
    bit          mpflag;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_ack, e_fs;
    bit          e_seg_chk;
    bit          m_step, m_wrap, m_blank;
    logic [3:0]  m_nib;

    // The display is a frame of four digits; tick rises reach the counter two clocks late.
    always @(posedge clk) begin
        if (!clr_n) begin
            hist = 3'b000; cnt = 0;
            mdisp = '0; mpend = '0; mddp = '0; mpdp = '0; mpflag = 1'b0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_ack = 1'b0; e_fs = 1'b0;
            e_seg_chk = 1'b1;
            mvalid = 1'b1;
        end else begin
            m_step  = hist[1] && !hist[2];
            m_wrap  = m_step && (cnt == 3);
            m_blank = bus.blank_lz && (cnt > 0) && ((mdisp >> (4 * cnt)) == 16'h0);
            m_nib   = mdisp[4*cnt +: 4];
            e_an      = m_blank ? 4'hF : ~(4'b0001 << cnt);
            e_seg     = SEG_TAB[m_nib];
            e_seg_chk = !m_blank;
            e_dp      = !(mddp[cnt] && !m_blank);
            e_ack     = m_wrap && mpflag;
            e_fs      = m_wrap;
            if (m_wrap && mpflag) begin
                mdisp = mpend; mddp = mpdp; mpflag = 1'b0;
            end
            if (bus.load) begin
                mpend = bus.data_in; mpdp = bus.dp_in; mpflag = 1'b1;
            end
            if (m_step) cnt = (cnt + 1) % 4;
            hist = {hist[1:0], bus.scan_tick_in};
        end
    end

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endfunction

    task automatic cycle();
        @(negedge clk);
        if (bus.load_ack === 1'b1) ack_seen++;
        if (bus.frame_start === 1'b1) fs_seen++;
        if (mvalid) begin
            chk("model_an",  32'(bus.an),          32'(e_an));
            chk("model_dp",  32'(bus.dp),          32'(e_dp));
            chk("model_ack", 32'(bus.load_ack),    32'(e_ack));
            chk("model_fs",  32'(bus.frame_start), 32'(e_fs));
            if (e_seg_chk) chk("model_seg", 32'(bus.a_to_g), 32'(e_seg));
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        bus.load = 1'b1; bus.data_in = v; bus.dp_in = d;
        cycle();
        bus.load = 1'b0;
    endtask

    task automatic tick_pulse();
        bus.scan_tick_in = 1'b1;
        repeat (4) cycle();
        bus.scan_tick_in = 1'b0;
        repeat (4) cycle();
    endtask

    // Places a load on exactly the clock edge where the step takes effect.
    task automatic tick_with_load(input logic [15:0] v, input logic [3:0] d);
        bus.scan_tick_in = 1'b1;
        cycle();
        cycle();
        bus.load = 1'b1; bus.data_in = v; bus.dp_in = d;
        cycle();
        bus.load = 1'b0;
        cycle();
        bus.scan_tick_in = 1'b0;
        repeat (4) cycle();
    endtask

    task automatic show(input string name, input logic [3:0] an, input logic [6:0] seg, input logic dp);
        chk({name, "_an"}, 32'(bus.an), 32'(an));
        if (an != 4'hF) chk({name, "_seg"}, 32'(bus.a_to_g), 32'(seg));
        chk({name, "_dp"}, 32'(bus.dp), 32'(dp));
    endtask

    int a0, f0;

    initial begin
        clr_n = 1'b0;
        bus.scan_tick_in = 1'b0; bus.data_in = '0; bus.dp_in = '0;
        bus.load = 1'b0; bus.blank_lz = 1'b0;

        // Reset with the tick toggling
        for (int i = 0; i < 3; i++) begin
            bus.scan_tick_in = ~bus.scan_tick_in;
            cycle();
        end
        chk("rst_an",  32'(bus.an),       'hF);
        chk("rst_seg", 32'(bus.a_to_g),   'h7F);
        chk("rst_dp",  32'(bus.dp),       1);
        chk("rst_ack", 32'(bus.load_ack), 0);
        chk("rst_dig", 32'(dut.dig),      0);
        bus.scan_tick_in = 1'b0;
        clr_n = 1'b1;
        cycle(); cycle();
        show("idle", 4'b1110, 7'b0000001, 1'b1);

        // Basic scan of 0x1A2F
        do_load(16'h1A2F, 4'b0000);
        a0 = ack_seen; f0 = fs_seen;
        repeat (4) tick_pulse();
        chk("basic_ack1", 32'(ack_seen - a0), 1);
        chk("basic_fs1",  32'(fs_seen - f0),  1);
        show("basic_d0", 4'b1110, 7'b0111000, 1'b1);
        tick_pulse(); show("basic_d1", 4'b1101, 7'b0010010, 1'b1);
        tick_pulse(); show("basic_d2", 4'b1011, 7'b0001000, 1'b1);
        tick_pulse(); show("basic_d3", 4'b0111, 7'b1001111, 1'b1);
        tick_pulse();
        chk("basic_ack2", 32'(ack_seen - a0), 1);
        chk("basic_fs2",  32'(fs_seen - f0),  2);

        // Overwrite before commit: only the last load shows, one ack
        a0 = ack_seen;
        do_load(16'h1111, 4'b0000);
        tick_pulse();
        do_load(16'h2222, 4'b0000);
        repeat (3) tick_pulse();
        chk("tear_ack", 32'(ack_seen - a0), 1);
        for (int k = 0; k < 4; k++) begin
            chk("tear_seg", 32'(bus.a_to_g), 32'(7'b0010010));
            if (k < 3) tick_pulse();
        end

        // Load collides with the commit edge
        a0 = ack_seen;
        do_load(16'h3333, 4'b0000);
        tick_with_load(16'h4444, 4'b0000);
        chk("coll_ack1", 32'(ack_seen - a0), 1);
        show("coll_d0", 4'b1110, 7'b0000110, 1'b1);
        repeat (3) tick_pulse();
        show("coll_d3", 4'b0111, 7'b0000110, 1'b1);
        tick_pulse();
        chk("coll_ack2", 32'(ack_seen - a0), 2);
        show("coll_new", 4'b1110, 7'b1001100, 1'b1);

        // Leading-zero blanking
        bus.blank_lz = 1'b1;
        do_load(16'h0050, 4'b1111);
        repeat (4) tick_pulse();
        show("blank_d0", 4'b1110, 7'b0000001, 1'b0);
        tick_pulse(); show("blank_d1", 4'b1101, 7'b0100100, 1'b0);
        tick_pulse(); show("blank_d2", 4'b1111, 7'b0000000, 1'b1);
        tick_pulse(); show("blank_d3", 4'b1111, 7'b0000000, 1'b1);
        do_load(16'h0000, 4'b0000);
        tick_pulse(); show("zero_d0", 4'b1110, 7'b0000001, 1'b1);
        tick_pulse(); show("zero_d1", 4'b1111, 7'b0000000, 1'b1);
        tick_pulse(); show("zero_d2", 4'b1111, 7'b0000000, 1'b1);
        tick_pulse(); show("zero_d3", 4'b1111, 7'b0000000, 1'b1);
        bus.blank_lz = 1'b0;

        // Tick held high: a single step (3 -> 0)
        f0 = fs_seen;
        bus.scan_tick_in = 1'b1;
        repeat (1000) cycle();
        bus.scan_tick_in = 1'b0;
        repeat (4) cycle();
        chk("hold_fs", 32'(fs_seen - f0), 1);
        show("hold_d0", 4'b1110, 7'b0000001, 1'b1);

        // Reset at digit 2 with a load pending
        tick_pulse(); tick_pulse();
        a0 = ack_seen;
        do_load(16'hBEEF, 4'b1111);
        cycle();
        clr_n = 1'b0;
        cycle();
        chk("mrst_dig", 32'(dut.dig), 0);
        chk("mrst_an",  32'(bus.an),  'hF);
        clr_n = 1'b1;
        cycle();
        show("mrst_d0", 4'b1110, 7'b0000001, 1'b1);
        repeat (8) tick_pulse();
        chk("mrst_ack", 32'(ack_seen - a0), 0);
        show("mrst_end", 4'b1110, 7'b0000001, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Time-multiplexed 4-digit 7-segment driver. Sits directly downstream of the clock divider and consumes its slow square-wave output (~48 Hz or ~95 Hz tap) as a refresh-step request.
- Takes a 16-bit hex value from the ROM data-processing path and drives shared segment lines plus per-digit anodes.
- Value updates go through a load/ack handshake and commit only at frame boundaries, so a displayed frame never mixes old and new data.

Parameters:
- SYNC_EN, 1, 1 = pass scan_tick_in through a 2-flop synchroniser; 0 = use the input directly as the edge-detector source (tick already a clean clk-domain register).
- SEG_ACTIVE_LOW, 1, 1 = segment and dp outputs are active-low.
- AN_ACTIVE_LOW, 1, 1 = anode outputs are active-low.

Ports:
- clk  in  1  system clock
- clr_n  in  1  synchronous active-low reset
- scan_tick_in  in  1  divider tap, level signal; each rising edge advances one digit
- data_in  in  16  hex value; nibble 3 = leftmost digit
- dp_in  in  4  decimal-point enables, bit i = digit i
- load  in  1  1-cycle request to capture data_in/dp_in
- blank_lz  in  1  leading-zero blanking enable (level, sampled every cycle)
- load_ack  out  1  1-cycle pulse when the pending value is committed to the display
- frame_start  out  1  1-cycle pulse when the digit index wraps 3->0
- an  out  4  digit enables
- a_to_g  out  7  segments; bit 6 = a ... bit 0 = g
- dp  out  1  decimal point for the active digit

Behaviour:
- Reset (clr_n = 0 at a clk edge) clears everything:
  - sync flops, prev, dig, disp_val, disp_dp, pend_val, pend_dp and pend_flag go to 0.
  - Outputs go to "all off": an inactive, a_to_g inactive, dp inactive, load_ack = 0, frame_start = 0.
  - A reset mid-frame or with a load pending discards the pending value and issues no ack.
- Edge detect:
  - Chain is sync0 -> sync1 -> prev. The sync stages are omitted when SYNC_EN = 0.
  - step = sync1 & ~prev. One step per input rising edge; falling edges are ignored.
  - Latency from input rise to step: 2 clk cycles with SYNC_EN = 1, 0 cycles otherwise.
- Digit counter dig[1:0]: on step, dig <= dig + 1, with 3 wrapping to 0.
- Frame commit fires on a step while dig == 3. In that same edge:
  - If pend_flag is set: disp_val <= pend_val, disp_dp <= pend_dp, pend_flag <= 0, and load_ack pulses.
  - frame_start pulses whether or not a commit happens.
- Load handling:
  - load = 1 sets pend_val <= data_in, pend_dp <= dp_in and pend_flag <= 1.
  - Back-to-back loads before a commit overwrite; the last one wins, and only one ack is issued.
  - Load and commit in the same cycle: the commit uses the pending contents from before the edge. The new load stays pending (pend_flag stays 1) and commits at the next frame, with its own ack.
  - Load with no prior pending value, same cycle as commit: there is no commit and no ack. The load waits for the next frame.
- Leading-zero blanking:
  - Digit k (k = 3, 2, 1) is blank when blank_lz = 1 and disp_val nibbles 3..k are all zero.
  - Digit 0 is never blanked, so 0x0000 shows "0".
  - A blanked digit has its anode inactive and its dp inactive.
- Outputs are registered from dig, disp_val, disp_dp and blank_lz, so they lag dig by 1 clk.
  - Exactly one anode is active at a time, except when the current digit is blanked, in which case none is.
- Segment encoding (active-low form, SEG_ACTIVE_LOW = 1); the values are inverted when the parameter is 0:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110
  - 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111
  - 8 = 0000000, 9 = 0000100, A = 0001000, b = 1100000
  - C = 0110001, d = 1000010, E = 0110000, F = 0111000
- scan_tick_in held static: dig freezes, and the current digit stays lit indefinitely.

Decomposition:
- Shared package seg7_pkg holds:
  - the 16-entry hex-to-segment constant table (active-low form)
  - constants DIGITS = 4 and SEG_OFF = 7'h7F
- One combinational sub-module, hex7seg: 4-bit nibble in, 7-bit active-low pattern out. seg7_scan instantiates it once on the muxed nibble and applies the polarity parameter.
- Synchroniser and edge detect stay inline.

Test Plan:
- Reset: hold clr_n = 0 for 3 cycles while toggling scan_tick_in -> an = 4'b1111, a_to_g = 7'h7F, dp = 1, load_ack = 0, dig = 0.
- Basic scan: load 0x1A2F, dp_in = 4'b0000; apply 8 tick rising edges.
  - load_ack fires on the first 3->0 wrap.
  - The next frame shows an = 1110/1101/1011/0111 with a_to_g = F(0111000), 2(0010010), A(0001000), 1(1001111), each 1 clk after its step.
- Tearing and overwrite: load 0x1111, then 0x2222 mid-frame, both before the wrap -> exactly one load_ack; the frame shows 2222 on every digit, never 1111.
- Same-cycle collision: pending = 0x3333, then load 0x4444 on the commit cycle.
  - That frame commits 0x3333 with an ack.
  - The next wrap commits 0x4444 with a second ack.
- Blanking: blank_lz = 1, value 0x0050 -> digits 3 and 2 have anodes inactive and dp off; digit 1 shows 5, digit 0 shows 0. Value 0x0000 shows only digit 0 = "0".
- Edge and reset corner cases:
  - scan_tick_in held high for 1000 cycles gives exactly one step.
  - clr_n pulsed low during dig = 2 with a load pending -> dig = 0, display shows 0, no ack ever issued for that load.
